serial_word_loader: RTL and testbench

Upstream feeder for the 8-bit write-enable register stage. Assembles a serial bit stream into a parallel word, with optional parity check. Presents the word on DATA together with a one-cycle active-low EWR write strobe, which the register consumes directly. This block is clocked on posedge CLOCK; the register samples on negedge, so DATA/EWR are stable half a cycle before capture.

---
 rtl/serial_word_loader_pkg.sv | 15 +
 rtl/serial_word_loader_if.sv | 33 +++
 rtl/serial_word_loader.sv | 140 ++++++++++++++
 tb/tb_serial_word_loader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_word_loader_pkg.sv
// Shared definitions for the serial word loader and the register stage it feeds.
package serial_word_loader_pkg;

  // Default MSB index of the loaded word; the register stage uses the same value.
  localparam int DEFAULT_NUMBITS = 7;

  // Loader FSM encodings.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_LOAD  = 2'd3
  } state_t;

endpackage

// File: rtl/serial_word_loader_if.sv
// Bus between a serial feeder (master) and the serial word loader (slave).
//
// Handshake: a serial bit on SIN is transferred only on a CLOCK posedge where
// SVALID=1 and the loader is in SHIFT or PAR. There is no back-pressure; the
// loader always accepts a qualified bit. START and ABORT are level controls
// sampled on posedge. EWR is an active-low strobe, low for exactly one cycle
// while DATA holds a freshly loaded word. STATE exposes the FSM for debug.
interface serial_word_loader_if #(
  parameter int NUMBITS = 7
);
  import serial_word_loader_pkg::*;

  logic               START;
  logic               SIN;
  logic               SVALID;
  logic               ABORT;
  logic [NUMBITS:0]   DATA;
  logic               EWR;
  logic               BUSY;
  logic               PERR;
  logic [3:0]         BITCNT;
  state_t             STATE;

  modport master (
    output START, SIN, SVALID, ABORT,
    input  DATA, EWR, BUSY, PERR, BITCNT, STATE
  );

  modport slave (
    input  START, SIN, SVALID, ABORT,
    output DATA, EWR, BUSY, PERR, BITCNT, STATE
  );
endinterface

// File: rtl/serial_word_loader.sv
// Assembles a serial bit stream into a word, optionally checks even parity,
// and presents the word with a one-cycle active-low write strobe (EWR).
// All outputs are registered so the negedge-sampling register stage sees
// DATA/EWR stable half a cycle before capture.
module serial_word_loader
  import serial_word_loader_pkg::*;
#(
  parameter int NUMBITS   = DEFAULT_NUMBITS,
  parameter bit PARITY_EN = 1'b1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  serial_word_loader_if.slave  bus
);

  localparam logic [3:0] LAST_IDX = 4'(NUMBITS);
  localparam logic [3:0] CNT_MAX  = 4'(NUMBITS + 1);

  state_t           r_state;
  logic [NUMBITS:0] r_shift;
  logic [NUMBITS:0] r_data;
  logic             r_ewr_n;
  logic             r_busy;
  logic             r_perr;
  logic [3:0]       r_bitcnt;

  state_t           w_state_nxt;
  logic [NUMBITS:0] w_shift_nxt;
  logic [NUMBITS:0] w_shift_in;
  logic [NUMBITS:0] w_data_nxt;
  logic             w_ewr_n_nxt;
  logic             w_busy_nxt;
  logic             w_perr_nxt;
  logic [3:0]       w_bitcnt_nxt;

  // Shift register with the incoming bit inserted per bit-order setting.
  assign w_shift_in = MSB_FIRST ? {r_shift[NUMBITS-1:0], bus.SIN}
                                : {bus.SIN, r_shift[NUMBITS:1]};

  // Register all state and outputs; reset forces EWR high so no partial word is written.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_data   <= '0;
      r_ewr_n  <= 1'b1;
      r_busy   <= 1'b0;
      r_perr   <= 1'b0;
      r_bitcnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_data   <= w_data_nxt;
      r_ewr_n  <= w_ewr_n_nxt;
      r_busy   <= w_busy_nxt;
      r_perr   <= w_perr_nxt;
      r_bitcnt <= w_bitcnt_nxt;
    end
  end

  // Next-state and next-output logic; EWR defaults high and drops only on LOAD entry.
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_data_nxt   = r_data;
    w_ewr_n_nxt  = 1'b1;
    w_perr_nxt   = r_perr;
    w_bitcnt_nxt = r_bitcnt;

    case (r_state)
      ST_IDLE: begin
        // ABORT beats START; SIN in the START cycle is not consumed.
        if (bus.START && !bus.ABORT) begin
          w_state_nxt  = ST_SHIFT;
          w_shift_nxt  = '0;
          w_bitcnt_nxt = '0;
          w_perr_nxt   = 1'b0;
        end
      end

      ST_SHIFT: begin
        if (bus.ABORT) begin
          w_state_nxt  = ST_IDLE;
          w_bitcnt_nxt = '0;
        end else if (bus.SVALID) begin
          w_shift_nxt = w_shift_in;
          if (r_bitcnt < CNT_MAX) begin
            w_bitcnt_nxt = r_bitcnt + 4'd1;
          end
          if (r_bitcnt == LAST_IDX) begin
            if (PARITY_EN) begin
              w_state_nxt = ST_PAR;
            end else begin
              w_state_nxt = ST_LOAD;
              w_data_nxt  = w_shift_in;
              w_ewr_n_nxt = 1'b0;
            end
          end
        end
      end

      ST_PAR: begin
        if (bus.ABORT) begin
          w_state_nxt  = ST_IDLE;
          w_bitcnt_nxt = '0;
        end else if (bus.SVALID) begin
          // Even parity: the parity bit equals the XOR of the data bits.
          if (bus.SIN == ^r_shift) begin
            w_state_nxt = ST_LOAD;
            w_data_nxt  = r_shift;
            w_ewr_n_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_IDLE;
            w_perr_nxt  = 1'b1;
          end
        end
      end

      ST_LOAD: begin
        // Single write cycle; START and ABORT are ignored here.
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt == ST_SHIFT) || (w_state_nxt == ST_PAR);
  end

  assign bus.DATA   = r_data;
  assign bus.EWR    = r_ewr_n;
  assign bus.BUSY   = r_busy;
  assign bus.PERR   = r_perr;
  assign bus.BITCNT = r_bitcnt;
  assign bus.STATE  = r_state;

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed bench for serial_word_loader. Two instances share one stimulus
// stream: dut_a assembles LSB-first, dut_b MSB-first, both with parity.
// A small negedge register models the downstream write-enable stage.
module tb_serial_word_loader;
  import serial_word_loader_pkg::*;

  logic clk;
  logic rst_n;
  logic t_start, t_sin, t_svalid, t_abort;

  int n_chk  = 0;
  int n_fail = 0;
  int pulses_a = 0;
  int pulses_b = 0;
  logic [7:0] reg_q = 8'h00;

  serial_word_loader_if #(.NUMBITS(7)) ifa ();
  serial_word_loader_if #(.NUMBITS(7)) ifb ();

  assign ifa.START  = t_start;
  assign ifa.SIN    = t_sin;
  assign ifa.SVALID = t_svalid;
  assign ifa.ABORT  = t_abort;
  assign ifb.START  = t_start;
  assign ifb.SIN    = t_sin;
  assign ifb.SVALID = t_svalid;
  assign ifb.ABORT  = t_abort;

  serial_word_loader #(.NUMBITS(7), .PARITY_EN(1'b1), .MSB_FIRST(1'b0)) dut_a (
    .CLOCK (clk),
    .RESET (rst_n),
    .bus   (ifa)
  );

  serial_word_loader #(.NUMBITS(7), .PARITY_EN(1'b1), .MSB_FIRST(1'b1)) dut_b (
    .CLOCK (clk),
    .RESET (rst_n),
    .bus   (ifb)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  // Downstream register (negedge capture) and EWR pulse counters.
  always @(negedge clk) begin
    if (ifa.EWR === 1'b0) begin
      pulses_a++;
      reg_q <= ifa.DATA;
    end
    if (ifb.EWR === 1'b0) pulses_b++;
  end

  // Driver tasks: each waits for a negedge, then drives the next cycle's inputs.
  task automatic drv_idle();
    @(negedge clk);
    t_start = 1'b0; t_svalid = 1'b0; t_abort = 1'b0; t_sin = 1'b0;
  endtask

  task automatic drv_start();
    @(negedge clk);
    // SVALID/SIN high here must not be consumed.
    t_start = 1'b1; t_svalid = 1'b1; t_abort = 1'b0; t_sin = 1'b1;
  endtask

  task automatic drv_bit(input logic b);
    @(negedge clk);
    t_start = 1'b0; t_svalid = 1'b1; t_abort = 1'b0; t_sin = b;
  endtask

  task automatic drv_frame(input logic [7:0] w, input logic p);
    for (int i = 0; i < 8; i++) drv_bit(w[i]);
    drv_bit(p);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk++; if (ifa.EWR !== 1'b1) begin n_fail++; $display("FAIL reset_ewr: got %b want 1", ifa.EWR); end
    n_chk++; if (ifa.DATA !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", ifa.DATA); end
    n_chk++; if (ifa.BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", ifa.BUSY); end
    n_chk++; if (ifa.PERR !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", ifa.PERR); end
    n_chk++; if (ifa.BITCNT !== 4'd0) begin n_fail++; $display("FAIL reset_bitcnt: got %0d want 0", ifa.BITCNT); end
    n_chk++; if (ifa.STATE !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want 0", ifa.STATE); end
    rst_n = 1'b1;
  endtask

  task automatic test_good_frame();
    int p0;
    logic [7:0] w;
    p0 = pulses_a;
    w  = 8'hA5;
    drv_start();
    drv_bit(w[0]);
    n_chk++; if (ifa.BUSY !== 1'b1) begin n_fail++; $display("FAIL good_busy_start: got %b want 1", ifa.BUSY); end
    n_chk++; if (ifa.BITCNT !== 4'd0) begin n_fail++; $display("FAIL good_bitcnt_start: got %0d want 0", ifa.BITCNT); end
    for (int i = 1; i < 8; i++) drv_bit(w[i]);
    drv_bit(1'b0);
    n_chk++; if (ifa.BITCNT !== 4'd8) begin n_fail++; $display("FAIL good_bitcnt_full: got %0d want 8", ifa.BITCNT); end
    n_chk++; if (ifa.STATE !== ST_PAR) begin n_fail++; $display("FAIL good_state_par: got %0d want 2", ifa.STATE); end
    n_chk++; if (ifa.EWR !== 1'b1) begin n_fail++; $display("FAIL good_ewr_early: got %b want 1", ifa.EWR); end
    drv_idle();
    n_chk++; if (ifa.EWR !== 1'b0) begin n_fail++; $display("FAIL good_ewr_low: got %b want 0", ifa.EWR); end
    n_chk++; if (ifa.DATA !== 8'hA5) begin n_fail++; $display("FAIL good_data: got %h want a5", ifa.DATA); end
    n_chk++; if (ifa.PERR !== 1'b0) begin n_fail++; $display("FAIL good_perr: got %b want 0", ifa.PERR); end
    n_chk++; if (ifa.STATE !== ST_LOAD) begin n_fail++; $display("FAIL good_state_load: got %0d want 3", ifa.STATE); end
    drv_idle();
    n_chk++; if (ifa.EWR !== 1'b1) begin n_fail++; $display("FAIL good_ewr_high: got %b want 1", ifa.EWR); end
    n_chk++; if (ifa.BUSY !== 1'b0) begin n_fail++; $display("FAIL good_busy_end: got %b want 0", ifa.BUSY); end
    n_chk++; if (reg_q !== 8'hA5) begin n_fail++; $display("FAIL good_reg: got %h want a5", reg_q); end
    n_chk++; if (pulses_a !== p0 + 1) begin n_fail++; $display("FAIL good_pulses: got %0d want %0d", pulses_a, p0 + 1); end
  endtask

  task automatic test_parity_error();
    int p0;
    p0 = pulses_a;
    drv_start();
    drv_frame(8'hA5, 1'b1);
    drv_idle();
    n_chk++; if (ifa.PERR !== 1'b1) begin n_fail++; $display("FAIL perr_flag: got %b want 1", ifa.PERR); end
    n_chk++; if (ifa.EWR !== 1'b1) begin n_fail++; $display("FAIL perr_ewr: got %b want 1", ifa.EWR); end
    n_chk++; if (ifa.STATE !== ST_IDLE) begin n_fail++; $display("FAIL perr_state: got %0d want 0", ifa.STATE); end
    n_chk++; if (ifa.DATA !== 8'hA5) begin n_fail++; $display("FAIL perr_data: got %h want a5", ifa.DATA); end
    drv_idle();
    n_chk++; if (ifa.PERR !== 1'b1) begin n_fail++; $display("FAIL perr_sticky: got %b want 1", ifa.PERR); end
    n_chk++; if (pulses_a !== p0) begin n_fail++; $display("FAIL perr_pulses: got %0d want %0d", pulses_a, p0); end
  endtask

  task automatic test_svalid_gaps_msb();
    int p0;
    p0 = pulses_b;
    drv_start();
    drv_bit(1'b1);
    drv_bit(1'b0);
    drv_idle();
    n_chk++; if (ifb.BITCNT !== 4'd2) begin n_fail++; $display("FAIL gap_bitcnt2: got %0d want 2", ifb.BITCNT); end
    n_chk++; if (ifb.PERR !== 1'b0) begin n_fail++; $display("FAIL gap_perr_clr: got %b want 0", ifb.PERR); end
    drv_bit(1'b0);
    n_chk++; if (ifb.BITCNT !== 4'd2) begin n_fail++; $display("FAIL gap_bitcnt_hold: got %0d want 2", ifb.BITCNT); end
    drv_bit(1'b0);
    drv_bit(1'b0);
    drv_idle();
    drv_bit(1'b0);
    drv_bit(1'b0);
    drv_bit(1'b1);
    drv_idle();
    n_chk++; if (ifb.STATE !== ST_PAR) begin n_fail++; $display("FAIL gap_state_par: got %0d want 2", ifb.STATE); end
    drv_bit(1'b0);
    n_chk++; if (ifb.EWR !== 1'b1) begin n_fail++; $display("FAIL gap_ewr_wait: got %b want 1", ifb.EWR); end
    drv_idle();
    n_chk++; if (ifb.EWR !== 1'b0) begin n_fail++; $display("FAIL gap_ewr_low: got %b want 0", ifb.EWR); end
    n_chk++; if (ifb.DATA !== 8'h81) begin n_fail++; $display("FAIL gap_data_msb: got %h want 81", ifb.DATA); end
    n_chk++; if (ifa.DATA !== 8'h81) begin n_fail++; $display("FAIL gap_data_lsb: got %h want 81", ifa.DATA); end
    drv_idle();
    n_chk++; if (pulses_b !== p0 + 1) begin n_fail++; $display("FAIL gap_pulses: got %0d want %0d", pulses_b, p0 + 1); end
  endtask

  task automatic test_abort();
    int p0;
    p0 = pulses_a;
    drv_start();
    drv_bit(1'b1); drv_bit(1'b1); drv_bit(1'b0); drv_bit(1'b1); drv_bit(1'b0);
    @(negedge clk);
    n_chk++; if (ifa.BITCNT !== 4'd5) begin n_fail++; $display("FAIL abort_bitcnt5: got %0d want 5", ifa.BITCNT); end
    t_svalid = 1'b0; t_abort = 1'b1;
    drv_idle();
    n_chk++; if (ifa.BUSY !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", ifa.BUSY); end
    n_chk++; if (ifa.BITCNT !== 4'd0) begin n_fail++; $display("FAIL abort_bitcnt: got %0d want 0", ifa.BITCNT); end
    n_chk++; if (ifa.STATE !== ST_IDLE) begin n_fail++; $display("FAIL abort_state: got %0d want 0", ifa.STATE); end
    n_chk++; if (ifa.DATA !== 8'h81) begin n_fail++; $display("FAIL abort_data: got %h want 81", ifa.DATA); end
    @(negedge clk);
    t_start = 1'b1; t_abort = 1'b1;
    drv_idle();
    n_chk++; if (ifa.STATE !== ST_IDLE) begin n_fail++; $display("FAIL abort_start_state: got %0d want 0", ifa.STATE); end
    n_chk++; if (ifa.BUSY !== 1'b0) begin n_fail++; $display("FAIL abort_start_busy: got %b want 0", ifa.BUSY); end
    n_chk++; if (pulses_a !== p0) begin n_fail++; $display("FAIL abort_pulses: got %0d want %0d", pulses_a, p0); end
    drv_start();
    drv_frame(8'hFF, 1'b0);
    drv_idle();
    n_chk++; if (ifa.EWR !== 1'b0) begin n_fail++; $display("FAIL ff_ewr: got %b want 0", ifa.EWR); end
    n_chk++; if (ifa.DATA !== 8'hFF) begin n_fail++; $display("FAIL ff_data: got %h want ff", ifa.DATA); end
    drv_idle();
  endtask

  task automatic test_back_to_back();
    int p0;
    logic [7:0] w;
    p0 = pulses_a;
    w  = 8'h34;
    drv_start();
    drv_frame(8'h12, 1'b0);
    @(negedge clk);
    t_start = 1'b1; t_svalid = 1'b0;
    n_chk++; if (ifa.EWR !== 1'b0) begin n_fail++; $display("FAIL b2b_ewr1: got %b want 0", ifa.EWR); end
    n_chk++; if (ifa.DATA !== 8'h12) begin n_fail++; $display("FAIL b2b_data1: got %h want 12", ifa.DATA); end
    n_chk++; if (ifb.DATA !== 8'h48) begin n_fail++; $display("FAIL b2b_data1_msb: got %h want 48", ifb.DATA); end
    @(negedge clk);
    n_chk++; if (ifa.STATE !== ST_IDLE) begin n_fail++; $display("FAIL b2b_load_ignores_start: got %0d want 0", ifa.STATE); end
    n_chk++; if (ifa.EWR !== 1'b1) begin n_fail++; $display("FAIL b2b_ewr_gap: got %b want 1", ifa.EWR); end
    drv_bit(w[0]);
    n_chk++; if (ifa.STATE !== ST_SHIFT) begin n_fail++; $display("FAIL b2b_restart: got %0d want 1", ifa.STATE); end
    n_chk++; if (ifa.BITCNT !== 4'd0) begin n_fail++; $display("FAIL b2b_bitcnt: got %0d want 0", ifa.BITCNT); end
    for (int i = 1; i < 8; i++) drv_bit(w[i]);
    drv_bit(1'b1);
    drv_idle();
    n_chk++; if (ifa.EWR !== 1'b0) begin n_fail++; $display("FAIL b2b_ewr2: got %b want 0", ifa.EWR); end
    n_chk++; if (ifa.DATA !== 8'h34) begin n_fail++; $display("FAIL b2b_data2: got %h want 34", ifa.DATA); end
    n_chk++; if (ifb.DATA !== 8'h2C) begin n_fail++; $display("FAIL b2b_data2_msb: got %h want 2c", ifb.DATA); end
    drv_idle();
    n_chk++; if (pulses_a !== p0 + 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d want %0d", pulses_a, p0 + 2); end
  endtask

  task automatic test_reset_mid_frame();
    drv_start();
    drv_bit(1'b1); drv_bit(1'b0); drv_bit(1'b1); drv_bit(1'b1);
    drv_idle();
    n_chk++; if (ifa.BITCNT !== 4'd4) begin n_fail++; $display("FAIL rmid_bitcnt4: got %0d want 4", ifa.BITCNT); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (ifa.EWR !== 1'b1) begin n_fail++; $display("FAIL rmid_ewr: got %b want 1", ifa.EWR); end
    n_chk++; if (ifa.DATA !== 8'h00) begin n_fail++; $display("FAIL rmid_data: got %h want 00", ifa.DATA); end
    n_chk++; if (ifa.BUSY !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", ifa.BUSY); end
    n_chk++; if (ifa.BITCNT !== 4'd0) begin n_fail++; $display("FAIL rmid_bitcnt: got %0d want 0", ifa.BITCNT); end
    n_chk++; if (ifa.STATE !== ST_IDLE) begin n_fail++; $display("FAIL rmid_state: got %0d want 0", ifa.STATE); end
    @(negedge clk);
    rst_n = 1'b1;
    drv_start();
    drv_frame(8'h3C, 1'b0);
    drv_idle();
    n_chk++; if (ifa.EWR !== 1'b0) begin n_fail++; $display("FAIL rmid_ewr_after: got %b want 0", ifa.EWR); end
    n_chk++; if (ifa.DATA !== 8'h3C) begin n_fail++; $display("FAIL rmid_data_after: got %h want 3c", ifa.DATA); end
    drv_idle();
  endtask

  initial begin
    rst_n = 1'b0;
    t_start = 1'b0; t_sin = 1'b0; t_svalid = 1'b0; t_abort = 1'b0;
    test_reset();
    test_good_frame();
    test_parity_error();
    test_svalid_gaps_msb();
    test_abort();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
